// File: rtl/debug_hart_ctrl.sv
// Debug-module hart controller: halt/resume handshakes and abstract command
// dispatch to one selected hart, with sticky error reporting and a done timeout.
module debug_hart_ctrl #(
  parameter  int NUM_HARTS = 4,
  parameter  int XLEN      = 32,
  parameter  int TIMEOUT   = 1023,
  localparam int HSW       = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [HSW-1:0]            hartsel,
  input  logic                      halt_req,
  input  logic                      resume_req,
  input  logic                      exec,
  input  logic [31:0]               command,
  input  logic [XLEN-1:0]           data0_in,
  input  logic [XLEN-1:0]           data1_in,
  input  logic                      cmderr_clr,
  output logic [NUM_HARTS-1:0]      halted,
  output logic                      resumeack,
  output logic                      busy,
  output logic                      done,
  output logic                      write,
  output logic [2:0]                cmderr,
  output logic [XLEN-1:0]           data0_out,
  output logic [NUM_HARTS-1:0]      h_halt_req,
  output logic [NUM_HARTS-1:0]      h_resume_req,
  output logic [NUM_HARTS-1:0]      h_exec,
  output logic [31:0]               h_command,
  output logic [XLEN-1:0]           h_data0,
  output logic [XLEN-1:0]           h_data1,
  input  logic [NUM_HARTS-1:0]      h_halted,
  input  logic [NUM_HARTS-1:0]      h_done,
  input  logic [NUM_HARTS-1:0]      h_write,
  input  logic [NUM_HARTS-1:0]      h_error,
  input  logic [NUM_HARTS-1:0]      h_exception,
  input  logic [NUM_HARTS*XLEN-1:0] h_data0_out
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

  localparam logic [2:0] ERR_NONE   = 3'd0;
  localparam logic [2:0] ERR_BUSY   = 3'd1;
  localparam logic [2:0] ERR_UNSUP  = 3'd2;
  localparam logic [2:0] ERR_EXCEPT = 3'd3;
  localparam logic [2:0] ERR_HALT   = 3'd4;
  localparam logic [2:0] ERR_TMO    = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESUME
  } state_t;

  state_t                 r_state;
  logic [HSW-1:0]         r_sel_q;
  logic [CW-1:0]          r_cnt;
  logic [NUM_HARTS-1:0]   r_halted;
  logic [NUM_HARTS-1:0]   r_h_halt_req;
  logic [NUM_HARTS-1:0]   r_h_resume_req;
  logic [NUM_HARTS-1:0]   r_h_exec;
  logic                   r_resumeack;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_write;
  logic [2:0]             r_cmderr;
  logic [XLEN-1:0]        r_data0_out;
  logic [31:0]            r_h_command;
  logic [XLEN-1:0]        r_h_data0;
  logic [XLEN-1:0]        r_h_data1;

  logic [NUM_HARTS-1:0]   w_sel_onehot;
  logic                   w_sel_valid;
  logic                   w_sel_halted;
  logic [NUM_HARTS-1:0]   w_q_onehot;
  logic                   w_q_halted;
  logic                   w_q_done;
  logic                   w_q_write;
  logic                   w_q_error;
  logic                   w_q_exception;
  logic [XLEN-1:0]        w_q_data;
  logic                   w_exec_ok;

  // hartsel values beyond NUM_HARTS match no hart and so select nothing
  always_comb begin
    w_sel_onehot  = '0;
    w_sel_halted  = 1'b0;
    w_q_onehot    = '0;
    w_q_halted    = 1'b0;
    w_q_done      = 1'b0;
    w_q_write     = 1'b0;
    w_q_error     = 1'b0;
    w_q_exception = 1'b0;
    w_q_data      = '0;
    for (int unsigned i = 0; i < NUM_HARTS; i++) begin
      if (hartsel == HSW'(i)) begin
        w_sel_onehot[i] = 1'b1;
        w_sel_halted    = r_halted[i];
      end
      if (r_sel_q == HSW'(i)) begin
        w_q_onehot[i] = 1'b1;
        w_q_halted    = h_halted[i];
        w_q_done      = h_done[i];
        w_q_write     = h_write[i];
        w_q_error     = h_error[i];
        w_q_exception = h_exception[i];
        w_q_data      = h_data0_out[i*XLEN +: XLEN];
      end
    end
  end

  assign w_sel_valid = |w_sel_onehot;
  assign w_exec_ok   = exec && (r_cmderr == ERR_NONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_halted     <= '0;
      r_h_halt_req <= '0;
    end else begin
      r_halted     <= h_halted;
      r_h_halt_req <= halt_req ? w_sel_onehot : '0;
    end
  end

  // cmderr_clr is applied first so that any error raised on the same edge wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_sel_q        <= '0;
      r_cnt          <= '0;
      r_h_resume_req <= '0;
      r_h_exec       <= '0;
      r_resumeack    <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_write        <= 1'b0;
      r_cmderr       <= ERR_NONE;
      r_data0_out    <= '0;
      r_h_command    <= '0;
      r_h_data0      <= '0;
      r_h_data1      <= '0;
    end else begin
      r_h_exec    <= '0;
      r_done      <= 1'b0;
      r_resumeack <= 1'b0;
      if (cmderr_clr) begin
        r_cmderr <= ERR_NONE;
      end
      case (r_state)
        S_IDLE: begin
          if (w_exec_ok) begin
            if (w_sel_valid && w_sel_halted) begin
              r_sel_q     <= hartsel;
              r_h_command <= command;
              r_h_data0   <= data0_in;
              r_h_data1   <= data1_in;
              r_h_exec    <= w_sel_onehot;
              r_busy      <= 1'b1;
              r_cnt       <= '0;
              r_state     <= S_EXEC;
            end else begin
              r_cmderr <= ERR_HALT;
              r_write  <= 1'b0;
              r_done   <= 1'b1;
            end
          end else if (resume_req && w_sel_valid && w_sel_halted) begin
            r_sel_q        <= hartsel;
            r_h_resume_req <= w_sel_onehot;
            r_state        <= S_RESUME;
          end
        end
        S_EXEC: begin
          if (w_exec_ok) begin
            r_cmderr <= ERR_BUSY;
          end
          if (w_q_done) begin
            r_write <= w_q_write;
            if (w_q_write) begin
              r_data0_out <= w_q_data;
            end
            if (w_q_exception) begin
              r_cmderr <= ERR_EXCEPT;
            end else if (w_q_error) begin
              r_cmderr <= ERR_UNSUP;
            end
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_cnt == TO_VAL) begin
            r_cmderr <= ERR_TMO;
            r_write  <= 1'b0;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESUME: begin
          if (w_exec_ok) begin
            r_cmderr <= ERR_BUSY;
          end
          if (!w_q_halted) begin
            r_h_resume_req <= '0;
            r_resumeack    <= 1'b1;
            r_state        <= S_IDLE;
          end else begin
            r_h_resume_req <= w_q_onehot;
          end
        end
        default: begin
          r_state        <= S_IDLE;
          r_busy         <= 1'b0;
          r_h_resume_req <= '0;
        end
      endcase
    end
  end

  assign halted       = r_halted;
  assign resumeack    = r_resumeack;
  assign busy         = r_busy;
  assign done         = r_done;
  assign write        = r_write;
  assign cmderr       = r_cmderr;
  assign data0_out    = r_data0_out;
  assign h_halt_req   = r_h_halt_req;
  assign h_resume_req = r_h_resume_req;
  assign h_exec       = r_h_exec;
  assign h_command    = r_h_command;
  assign h_data0      = r_h_data0;
  assign h_data1      = r_h_data1;

endmodule

// File: tb/tb_debug_hart_ctrl.sv
// Randomized bench for debug_hart_ctrl against a transaction-level reference
// model (pending command with start edge, pending resume hart).
module tb_debug_hart_ctrl;
  localparam int NH   = 5;
  localparam int XL   = 32;
  localparam int TO   = 15;
  localparam int HS   = 3;
  localparam int NCYC = 6000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [HS-1:0]     hartsel;
  logic              halt_req, resume_req, exec, cmderr_clr;
  logic [31:0]       command;
  logic [XL-1:0]     data0_in, data1_in;
  logic [NH-1:0]     halted, h_halt_req, h_resume_req, h_exec;
  logic              resumeack, busy, done, write;
  logic [2:0]        cmderr;
  logic [XL-1:0]     data0_out, h_data0, h_data1;
  logic [31:0]       h_command;
  logic [NH-1:0]     h_halted, h_done, h_write, h_error, h_exception;
  logic [NH*XL-1:0]  h_data0_out;

  always #5 clk = ~clk;

  debug_hart_ctrl #(.NUM_HARTS(NH), .XLEN(XL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .hartsel(hartsel), .halt_req(halt_req),
    .resume_req(resume_req), .exec(exec), .command(command),
    .data0_in(data0_in), .data1_in(data1_in), .cmderr_clr(cmderr_clr),
    .halted(halted), .resumeack(resumeack), .busy(busy), .done(done),
    .write(write), .cmderr(cmderr), .data0_out(data0_out),
    .h_halt_req(h_halt_req), .h_resume_req(h_resume_req), .h_exec(h_exec),
    .h_command(h_command), .h_data0(h_data0), .h_data1(h_data1),
    .h_halted(h_halted), .h_done(h_done), .h_write(h_write),
    .h_error(h_error), .h_exception(h_exception), .h_data0_out(h_data0_out)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  logic [NH-1:0] e_halted, e_halt_req, e_resume_req, e_exec;
  logic          e_ack, e_busy, e_done, e_write;
  logic [2:0]    e_cmderr;
  logic [XL-1:0] e_data0, e_hd0, e_hd1;
  logic [31:0]   e_cmd;
  int            m_cmd_hart, m_res_hart, m_start, n_edge;
  int            n_timeouts, n_dones, n_acks;

  task automatic model_reset();
    e_halted = '0; e_halt_req = '0; e_resume_req = '0; e_exec = '0;
    e_ack = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_write = 1'b0;
    e_cmderr = '0; e_data0 = '0; e_hd0 = '0; e_hd1 = '0; e_cmd = '0;
    m_cmd_hart = -1; m_res_hart = -1; m_start = 0;
  endtask

  task automatic check_outputs();
    chk("halted", 64'(halted), 64'(e_halted));
    chk("h_halt_req", 64'(h_halt_req), 64'(e_halt_req));
    chk("h_resume_req", 64'(h_resume_req), 64'(e_resume_req));
    chk("h_exec", 64'(h_exec), 64'(e_exec));
    chk("resumeack", 64'(resumeack), 64'(e_ack));
    chk("busy", 64'(busy), 64'(e_busy));
    chk("done", 64'(done), 64'(e_done));
    chk("write", 64'(write), 64'(e_write));
    chk("cmderr", 64'(cmderr), 64'(e_cmderr));
    chk("data0_out", 64'(data0_out), 64'(e_data0));
    chk("h_command", 64'(h_command), 64'(e_cmd));
    chk("h_data0", 64'(h_data0), 64'(e_hd0));
    chk("h_data1", 64'(h_data1), 64'(e_hd1));
  endtask

  // Computes the outputs expected after the coming rising edge.
  task automatic model_step();
    int       hs;
    int       h;
    logic     sel_ok;
    logic [2:0] ce;
    hs     = int'(hartsel);
    sel_ok = 1'b0;
    if (hs < NH) sel_ok = e_halted[hs];
    n_edge++;
    ce     = cmderr_clr ? 3'd0 : e_cmderr;
    e_exec = '0; e_done = 1'b0; e_ack = 1'b0;
    if (m_cmd_hart >= 0) begin
      h = m_cmd_hart;
      if (exec && e_cmderr == 3'd0) ce = 3'd1;
      if (h_done[h]) begin
        e_write = h_write[h];
        if (h_write[h]) e_data0 = h_data0_out[h*XL +: XL];
        if (h_exception[h]) ce = 3'd3;
        else if (h_error[h]) ce = 3'd2;
        e_done = 1'b1; e_busy = 1'b0; m_cmd_hart = -1; n_dones++;
      end else if (n_edge - m_start == TO + 1) begin
        ce = 3'd7; e_write = 1'b0;
        e_done = 1'b1; e_busy = 1'b0; m_cmd_hart = -1; n_timeouts++;
      end
    end else if (m_res_hart >= 0) begin
      if (exec && e_cmderr == 3'd0) ce = 3'd1;
      if (!h_halted[m_res_hart]) begin
        e_resume_req = '0; e_ack = 1'b1; m_res_hart = -1; n_acks++;
      end
    end else if (exec && e_cmderr == 3'd0) begin
      if (sel_ok) begin
        e_cmd = command; e_hd0 = data0_in; e_hd1 = data1_in;
        e_exec = NH'(1) << hs; e_busy = 1'b1;
        m_cmd_hart = hs; m_start = n_edge;
      end else begin
        ce = 3'd4; e_done = 1'b1; e_write = 1'b0;
      end
    end else if (resume_req && sel_ok) begin
      e_resume_req = NH'(1) << hs; m_res_hart = hs;
    end
    e_cmderr   = ce;
    e_halted   = h_halted;
    e_halt_req = (halt_req && hs < NH) ? (NH'(1) << hs) : '0;
  endtask

  task automatic drive_random(input int cyc);
    int done_pct;
    done_pct   = ((cyc / 400) % 2 == 0) ? 25 : 3;
    hartsel    = HS'($urandom_range(0, 7));
    halt_req   = 1'($urandom % 2);
    resume_req = ($urandom % 6 == 0);
    exec       = ($urandom % 6 == 0);
    cmderr_clr = ($urandom % 10 == 0);
    command    = $urandom;
    data0_in   = $urandom;
    data1_in   = $urandom;
    for (int i = 0; i < NH; i++) begin
      if ($urandom % 12 == 0) h_halted[i] = ~h_halted[i];
      h_done[i]      = ($urandom_range(0, 99) < done_pct);
      h_write[i]     = 1'($urandom % 2);
      h_error[i]     = ($urandom % 4 == 0);
      h_exception[i] = ($urandom % 4 == 0);
      h_data0_out[i*XL +: XL] = $urandom;
    end
  endtask

  initial begin
    bit did_rst;
    did_rst = 1'b0;
    n_edge = 0; n_timeouts = 0; n_dones = 0; n_acks = 0;
    rst_n = 1'b0;
    hartsel = '0; halt_req = 1'b0; resume_req = 1'b0; exec = 1'b0;
    cmderr_clr = 1'b0; command = '0; data0_in = '0; data1_in = '0;
    h_halted = '0; h_done = '0; h_write = '0; h_error = '0;
    h_exception = '0; h_data0_out = '0;
    model_reset();
    #2;
    check_outputs();
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      drive_random(cyc);
      model_step();
      @(negedge clk);
      check_outputs();
      if (!did_rst && cyc >= 3000 && m_cmd_hart >= 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
        did_rst = 1'b1;
      end
    end
    if (n_timeouts == 0 || n_dones == 0 || n_acks == 0 || !did_rst) begin
      n_err++;
      $display("FAIL coverage: timeouts=%0d dones=%0d acks=%0d midreset=%0d (each required nonzero)",
               n_timeouts, n_dones, n_acks, did_rst);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
